// File: rtl/mult_sequencer_pkg.sv
// Shared constants for the multi-cycle multiplier sequencer: ALU op codes and FSM state encoding.
package mult_sequencer_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_LOOP   = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/mult_sequencer.sv
// MULT/MULTU sequencer: radix-2 shift-add product built one shared-ALU op per cycle,
// with sign handling done as ALU negations before and after the unsigned loop.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

  state_e             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [ITER_W-1:0]  iter_r;
  logic               signed_r;
  logic               a_neg_r;
  logic               b_neg_r;
  logic               lo_zero_r;
  logic               done_r;
  logic               ready_r;

  logic               accept_s;
  logic               prod_neg_s;
  logic               carry_s;

  assign accept_s   = start && ready_r;
  assign prod_neg_s = a_neg_r ^ b_neg_r;
  // Unsigned wrap of hi + addend is the carry out of the shared ALU.
  assign carry_s    = (alu_result < hi_r);

  assign ready = ready_r;
  assign busy  = ~ready_r;
  assign done  = done_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

  // Shared ALU operand/op selection, decoded from the current state.
  always_comb begin
    alu_in1     = {WIDTH{1'b0}};
    alu_in2     = {WIDTH{1'b0}};
    alu_control = ALU_NOP;
    case (state_r)
      ST_NEG_A: begin
        alu_in2     = mcand_r;
        alu_control = ALU_SUB;
      end
      ST_NEG_B, ST_NEG_LO: begin
        alu_in2     = lo_r;
        alu_control = ALU_SUB;
      end
      ST_LOOP: begin
        alu_in1     = hi_r;
        alu_in2     = lo_r[0] ? mcand_r : {WIDTH{1'b0}};
        alu_control = ALU_ADD;
      end
      ST_NEG_HI: begin
        alu_in2     = hi_r;
        alu_control = ALU_SUB;
      end
      default: begin
        alu_in1     = {WIDTH{1'b0}};
        alu_in2     = {WIDTH{1'b0}};
        alu_control = ALU_NOP;
      end
    endcase
  end

  // Sequencer FSM with registered status and product registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mcand_r   <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      iter_r    <= {ITER_W{1'b0}};
      signed_r  <= 1'b0;
      a_neg_r   <= 1'b0;
      b_neg_r   <= 1'b0;
      lo_zero_r <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            mcand_r  <= op_a;
            lo_r     <= op_b;
            hi_r     <= {WIDTH{1'b0}};
            iter_r   <= {ITER_W{1'b0}};
            signed_r <= is_signed;
            a_neg_r  <= is_signed & op_a[WIDTH-1];
            b_neg_r  <= is_signed & op_b[WIDTH-1];
            done_r   <= 1'b0;
            ready_r  <= 1'b0;
            state_r  <= is_signed ? ST_NEG_A : ST_LOOP;
          end else begin
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        ST_NEG_A: begin
          if (a_neg_r) begin
            mcand_r <= alu_result;
          end
          state_r <= ST_NEG_B;
        end
        ST_NEG_B: begin
          if (b_neg_r) begin
            lo_r <= alu_result;
          end
          state_r <= ST_LOOP;
        end
        ST_LOOP: begin
          hi_r   <= {carry_s, alu_result[WIDTH-1:1]};
          lo_r   <= {alu_result[0], lo_r[WIDTH-1:1]};
          iter_r <= iter_r + ITER_ONE;
          if (iter_r == LAST_ITER) begin
            if (signed_r) begin
              state_r <= ST_NEG_LO;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              ready_r <= 1'b1;
            end
          end
        end
        ST_NEG_LO: begin
          if (prod_neg_s) begin
            lo_zero_r <= (lo_r == {WIDTH{1'b0}});
            lo_r      <= alu_result;
          end
          state_r <= ST_NEG_HI;
        end
        ST_NEG_HI: begin
          // Borrow from the low-half negation only propagates when lo was zero.
          if (prod_neg_s) begin
            hi_r <= lo_zero_r ? alu_result : ~hi_r;
          end
          state_r <= ST_DONE;
          done_r  <= 1'b1;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed vector table, multi-cycle corner
// sequences and randomized operations against a 64-bit arithmetic reference.
module tb_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;

  int total;
  int bad;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_control(alu_control), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model
  always_comb begin
    case (alu_control)
      3'b010:  alu_result = alu_in1 + alu_in2;
      3'b110:  alu_result = alu_in1 - alu_in2;
      default: alu_result = 32'h0;
    endcase
  end

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] p;
    if (sgn) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      p  = 64'(sa * sb);
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output int lat, output int waited);
    waited = 0;
    while (!ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    is_signed = sgn;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rh = hi;
    rl = lo;
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] rh, rl, ra, rb;
  logic [63:0] p;
  logic        rs;
  int          lat, waited, pulses;

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    op_a      = 32'h0;
    op_b      = 32'h0;

    vecs[0] = '{1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 33};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[2] = '{1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 37};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 37};
    vecs[4] = '{1'b1, 32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 37};
    vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 37};
    vecs[6] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
    vecs[7] = '{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 37};

    // Reset state
    #12;
    chk("reset_status", {61'h0, ready, busy, done}, {61'h0, 1'b1, 1'b0, 1'b0});
    chk("reset_prod", {hi, lo}, 64'h0);
    chk("reset_alu", {alu_in1, alu_in2}, 64'h0);
    chk("reset_aluctl", {61'h0, alu_control}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, rh, rl, lat, waited);
      chk($sformatf("vec%0d_prod", i), {rh, rl}, {vecs[i].hi, vecs[i].lo});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse", i), {63'h0, done}, 64'h0);
      chk($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      chk($sformatf("vec%0d_idle_alu", i), {61'h0, alu_control}, 64'h0);
    end

    // start pulsed mid-operation is ignored
    is_signed = 1'b0; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      if (lat == 5) chk("loop_aluctl", {61'h0, alu_control}, 64'h2);
      if (lat == 10) begin
        start = 1'b1; op_a = 32'hDEADBEEF; op_b = 32'd7; is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore_prod", {hi, lo}, 64'd7006652);
    chk("ignore_lat", 64'(lat), 64'd33);

    // Back-to-back: new op accepted in DONE without an idle cycle
    do_op(1'b1, 32'hFFFFFFF0, 32'd3, rh, rl, lat, waited);
    chk("b2b_first", {rh, rl}, 64'hFFFFFFFF_FFFFFFD0);
    do_op(1'b0, 32'd100, 32'd200, rh, rl, lat, waited);
    chk("b2b_nowait", 64'(waited), 64'd0);
    chk("b2b_second", {rh, rl}, 64'd20000);
    chk("b2b_lat", 64'(lat), 64'd33);

    // Signed op: first busy cycle negates the multiplicand on the ALU
    @(posedge clk); #1;
    is_signed = 1'b1; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("nega_aluctl", {61'h0, alu_control}, 64'h6);
    chk("nega_busy", {62'h0, busy, ready}, 64'h2);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("nega_prod", {hi, lo}, 64'd81);

    // Reset in the middle of the loop
    @(posedge clk); #1;
    is_signed = 1'b0; op_a = 32'hABCD1234; op_b = 32'h12345678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_status", {61'h0, ready, busy, done}, {61'h0, 1'b1, 1'b0, 1'b0});
    chk("midrst_prod", {hi, lo}, 64'h0);
    chk("midrst_alu", {alu_in1, alu_in2, 29'h0, alu_control}, 96'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("midrst_nodone", 64'(pulses), 64'h0);
    do_op(1'b0, 32'd2, 32'd2, rh, rl, lat, waited);
    chk("midrst_fresh", {rh, rl}, 64'd4);

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      p = ref_prod(rs, ra, rb);
      do_op(rs, ra, rb, rh, rl, lat, waited);
      chk($sformatf("rnd%0d_prod", i), {rh, rl}, p);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), rs ? 64'd37 : 64'd33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
